// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- bus bundle between alu_seq and its environment.
//
// The environment is the instruction source, the register-load port and
// the external registered ALU. alu_seq connects through the slave modport.
// The environment (or a testbench) uses the master modport.
//
//   ins_valid / ins_ready / ins   instruction handshake (op rd rs rt)
//   ld_en / ld_addr / ld_data     external register load strobe
//   alu_cnt / alu_in0 / alu_in1   operation and operands to the ALU
//   alu_out                       registered ALU result
//   done / result                 writeback pulse and last written value
//   zf                            zero flag of the last writeback
//
// Optional feature macro: ALU_SEQ_ZF_EN. It adds the zf signal.
// ---------------------------------------------------------------------------
interface alu_seq_if;
    logic        ins_valid;
    logic        ins_ready;
    logic [10:0] ins;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_cnt;
    logic [15:0] alu_in0;
    logic [15:0] alu_in1;
    logic [15:0] alu_out;
    logic        done;
    logic [15:0] result;
`ifdef ALU_SEQ_ZF_EN
    logic        zf;
`endif

    modport master (
        output ins_valid, ins, ld_en, ld_addr, ld_data, alu_out,
        input  ins_ready, alu_cnt, alu_in0, alu_in1, done, result
`ifdef ALU_SEQ_ZF_EN
        , input zf
`endif
    );

    modport slave (
        input  ins_valid, ins, ld_en, ld_addr, ld_data, alu_out,
        output ins_ready, alu_cnt, alu_in0, alu_in1, done, result
`ifdef ALU_SEQ_ZF_EN
        , output zf
`endif
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- three-state sequencer that feeds an external registered ALU
// from an 8 x 16-bit register file and writes the result back.
//
// Ports:
//   clk   single clock; all state updates on the rising edge
//   rst   asynchronous reset, active low; clears all state
//   bus   alu_seq_if.slave; this modport carries:
//           ins_valid/ins_ready/ins  instruction handshake
//           ld_en/ld_addr/ld_data    external register load
//           alu_cnt/alu_in0/alu_in1  operation and operands to the ALU
//           alu_out                  ALU result, one clock after operands
//           done/result[/zf]         writeback pulse, value and zero flag
//
// Optional feature macro: ALU_SEQ_ZF_EN. When it is defined, the block
// keeps a zero-flag register and drives bus.zf. When it is not defined,
// the flag and its register do not exist.
//
// Sequence per instruction:
//   IDLE (ready)  -> accept edge: latch op and operands, and capture rd
//   EXEC          -> the ALU samples the stable operands on this edge
//   WB            -> write alu_out to r[rd], update result, pulse done
// ---------------------------------------------------------------------------
module alu_seq (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // The register file and the latched instruction context.
    logic [7:0][15:0] rf_q, rf_d;
    logic [1:0]       alu_cnt_q, alu_cnt_d;
    logic [15:0]      alu_in0_q, alu_in0_d;
    logic [15:0]      alu_in1_q, alu_in1_d;
    logic [2:0]       rd_q, rd_d;
    logic [15:0]      result_q, result_d;
    logic             done_q, done_d;
`ifdef ALU_SEQ_ZF_EN
    logic             zf_q, zf_d;
`endif

    // Instruction fields.
    logic [1:0] ins_op;
    logic [2:0] ins_rd, ins_rs, ins_rt;

    assign ins_op = bus.ins[10:9];
    assign ins_rd = bus.ins[8:6];
    assign ins_rs = bus.ins[5:3];
    assign ins_rt = bus.ins[2:0];

    logic accept;
    logic wb_en;

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ins_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = WB;
            WB: begin
                wb_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        rf_d      = rf_q;
        alu_cnt_d = alu_cnt_q;
        alu_in0_d = alu_in0_q;
        alu_in1_d = alu_in1_q;
        rd_d      = rd_q;
        result_d  = result_q;
        done_d    = wb_en;
`ifdef ALU_SEQ_ZF_EN
        zf_d      = zf_q;
`endif

        // The operands come from rf_q, which is the value before the edge.
        // A load on the accept edge therefore does not reach them.
        if (accept) begin
            alu_cnt_d = ins_op;
            alu_in0_d = rf_q[ins_rs];
            alu_in1_d = rf_q[ins_rt];
            rd_d      = ins_rd;
        end

        // The writeback is applied after the load. When both target the
        // same register, the ALU result wins.
        if (bus.ld_en)
            rf_d[bus.ld_addr] = bus.ld_data;
        if (wb_en) begin
            rf_d[rd_q] = bus.alu_out;
            result_d   = bus.alu_out;
`ifdef ALU_SEQ_ZF_EN
            zf_d       = (bus.alu_out == 16'h0000);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q      <= '0;
            alu_cnt_q <= 2'b00;
            alu_in0_q <= 16'h0000;
            alu_in1_q <= 16'h0000;
            rd_q      <= 3'd0;
            result_q  <= 16'h0000;
            done_q    <= 1'b0;
`ifdef ALU_SEQ_ZF_EN
            zf_q      <= 1'b0;
`endif
        end else begin
            rf_q      <= rf_d;
            alu_cnt_q <= alu_cnt_d;
            alu_in0_q <= alu_in0_d;
            alu_in1_q <= alu_in1_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            done_q    <= done_d;
`ifdef ALU_SEQ_ZF_EN
            zf_q      <= zf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ins_ready = (state_q == IDLE);
    assign bus.alu_cnt   = alu_cnt_q;
    assign bus.alu_in0   = alu_in0_q;
    assign bus.alu_in1   = alu_in1_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
`ifdef ALU_SEQ_ZF_EN
    assign bus.zf        = zf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
//
// The bench plays the role of the instruction source and of the external
// registered ALU. A register-file array holds the expected contents and is
// updated from the instruction-level rules. Each instruction checks:
//   - the latched operands against that model
//   - the handshake and done timing
//   - the written-back result
// A later instruction reads a register through its operands, so these
// operand checks also confirm the value held in that register.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if bus ();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_r [8];

    function automatic logic [15:0] ref_alu(input logic [1:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // External ALU: its output is registered, so a result is valid one
    // clock after the operands are presented.
    always @(posedge clk)
        bus.alu_out <= ref_alu(bus.alu_cnt, bus.alu_in0, bus.alu_in1);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins       = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"},   bus.ins_ready, 1);
        check({tag, "_alu_cnt"}, bus.alu_cnt,   0);
        check({tag, "_in0"},     bus.alu_in0,   0);
        check({tag, "_in1"},     bus.alu_in1,   0);
        check({tag, "_result"},  bus.result,    0);
        check({tag, "_done"},    bus.done,      0);
`ifdef ALU_SEQ_ZF_EN
        check({tag, "_zf"},      bus.zf,        0);
`endif
    endtask

    task automatic ld(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk);
        m_r[a] = d;
        #1 bus.ld_en = 1'b0;
    endtask

    // Runs one instruction through accept, EXEC and WB. ld_stage chooses
    // when an extra load is applied: 0 for no load, 1 on the accept edge,
    // 2 on the writeback edge.
    task automatic exec(input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input int ld_stage, input logic [2:0] la,
                        input logic [15:0] ldv, output logic [15:0] res);
        logic [15:0] a, b, e;
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.ins_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("idle_ready", bus.ins_ready, 1);
        bus.ins_valid = 1'b1;
        bus.ins       = {op, rd, rs, rt};
        if (ld_stage == 1) begin
            bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldv;
        end
        a = m_r[rs];
        b = m_r[rt];
        e = ref_alu(op, a, b);
        @(posedge clk);                       // accept edge N
        if (ld_stage == 1) m_r[la] = ldv;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        bus.ld_en     = 1'b0;
        check("exec_alu_cnt", bus.alu_cnt,   op);
        check("exec_in0",     bus.alu_in0,   a);
        check("exec_in1",     bus.alu_in1,   b);
        check("exec_ready",   bus.ins_ready, 0);
        check("exec_done",    bus.done,      0);
        @(posedge clk);                       // N+1
        @(negedge clk);
        check("wb_ready", bus.ins_ready, 0);
        check("wb_done",  bus.done,      0);
        check("wb_in0",   bus.alu_in0,   a);
        check("wb_in1",   bus.alu_in1,   b);
        if (ld_stage == 2) begin
            bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldv;
        end
        @(posedge clk);                       // N+2: writeback
        if (ld_stage == 2) m_r[la] = ldv;
        m_r[rd] = e;
        @(negedge clk);
        bus.ld_en = 1'b0;
        check("done_pulse",  bus.done,      1);
        check("done_result", bus.result,    e);
        check("done_ready",  bus.ins_ready, 1);
`ifdef ALU_SEQ_ZF_EN
        check("done_zf", bus.zf, (e == 16'h0000));
`endif
        res = bus.result;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] res;
        logic        rdy;
        int          k, dn;
        logic [15:0] b2b_exp [3];

        vecs[0] = '{2'b00, 16'h0005, 16'h0003, 16'h0008};
        vecs[1] = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE};
        vecs[2] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[3] = '{2'b01, 16'h1234, 16'h1234, 16'h0000};
        vecs[4] = '{2'b10, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[5] = '{2'b11, 16'hF000, 16'h000F, 16'hF00F};
        vecs[6] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[7] = '{2'b10, 16'hAAAA, 16'h5555, 16'h0000};

        // Reset state.
        do_reset();
        #1 check_zero_outputs("reset");

        // Basic add, then read r3 back through an operand.
        ld(3'd1, 16'h0005);
        ld(3'd2, 16'h0003);
        exec(2'b00, 3'd3, 3'd1, 3'd2, 0, 3'd0, 16'h0, res);
        check("add_r3", res, 16'h0008);
        exec(2'b11, 3'd7, 3'd3, 3'd3, 0, 3'd0, 16'h0, res);
        check("readback_r3", bus.alu_in0, 16'h0008);

        // Table of operations. This includes wraparound and zero results.
        for (int i = 0; i < 8; i++) begin
            ld(3'd1, vecs[i].a);
            ld(3'd2, vecs[i].b);
            exec(vecs[i].op, 3'd4, 3'd1, 3'd2, 0, 3'd0, 16'h0, res);
            check("vec_result", res, vecs[i].exp);
        end

        // rd may equal rs: the latched operands keep their old value.
        ld(3'd1, 16'h0003);
        exec(2'b01, 3'd1, 3'd1, 3'd1, 0, 3'd0, 16'h0, res);
        check("self_sub_zero", res, 16'h0000);

        // A load on the accept edge does not reach the operands.
        ld(3'd2, 16'h0011);
        exec(2'b00, 3'd5, 3'd2, 3'd2, 1, 3'd2, 16'h7777, res);
        check("ld_same_edge_unseen", res, 16'h0022);

        // Back-to-back: ins_valid is held high through three
        // r1 = r1 + r1 instructions.
        ld(3'd1, 16'h0001);
        b2b_exp[0] = 16'h0002; b2b_exp[1] = 16'h0004; b2b_exp[2] = 16'h0008;
        k = 0; dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rdy = bus.ins_ready;
            if (c < 9) check("b2b_ready", rdy, (c % 3 == 0) ? 1 : 0);
            if (bus.done) begin
                if (dn < 3) check("b2b_result", bus.result, b2b_exp[dn]);
                dn++;
            end
            if (k < 3) begin
                bus.ins_valid = 1'b1;
                bus.ins       = {2'b00, 3'd1, 3'd1, 3'd1};
            end else begin
                bus.ins_valid = 1'b0;
            end
            @(posedge clk);
            if (rdy && bus.ins_valid) k++;
        end
        bus.ins_valid = 1'b0;
        check("b2b_accepts", k, 3);
        check("b2b_dones", dn, 3);
        m_r[1] = 16'h0008;
        exec(2'b11, 3'd0, 3'd1, 3'd1, 0, 3'd0, 16'h0, res);
        check("b2b_final_r1", res, 16'h0008);

        // Writeback and load on the same edge.
        ld(3'd1, 16'h00F0);
        ld(3'd2, 16'h000F);
        exec(2'b11, 3'd3, 3'd1, 3'd2, 2, 3'd3, 16'h1234, res);
        exec(2'b11, 3'd4, 3'd1, 3'd2, 2, 3'd5, 16'hBEEF, res);
        exec(2'b11, 3'd0, 3'd3, 3'd5, 0, 3'd0, 16'h0, res);
        check("collide_r3_wb_wins", bus.alu_in0, 16'h00FF);
        check("collide_r5_written", bus.alu_in1, 16'hBEEF);

        // Reset while in EXEC.
        ld(3'd1, 16'h0007);
        ld(3'd2, 16'h0009);
        @(negedge clk);
        bus.ins_valid = 1'b1;
        bus.ins       = {2'b00, 3'd6, 3'd1, 3'd2};
        @(posedge clk);
        @(negedge clk);
        bus.ins_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check_zero_outputs("async_rst");
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end
        exec(2'b11, 3'd0, 3'd6, 3'd6, 0, 3'd0, 16'h0, res);
        check("abort_r6_zero", bus.alu_in0, 16'h0000);
        ld(3'd1, 16'h0007);
        ld(3'd2, 16'h0009);
        exec(2'b00, 3'd6, 3'd1, 3'd2, 0, 3'd0, 16'h0, res);
        check("post_rst_add", res, 16'h0010);

        // Random instructions and loads, checked against the model.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1)
                ld(3'($urandom_range(0, 7)), 16'($urandom));
            exec(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                 16'($urandom), res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 rst  input  1  asynchronous reset, active-low; clears all state when 0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 ins_valid  input  1  instruction present on ins.
REQ-004 ins_ready  output  1  block can accept an instruction this cycle.
REQ-005 ins  input  11  instruction: op[10:9], rd[8:6], rs[5:3], rt[2:0].
REQ-006 ld_en  input  1  external register load strobe.
REQ-007 ld_addr  input  3  register index for external load.
REQ-008 ld_data  input  16  data for external load.
REQ-009 alu_cnt  output  2  operation code driven to downstream ALU (00 add, 01 sub, 10 and, 11 or).
REQ-010 alu_in0  output  16  first ALU operand (value of rs).
REQ-011 alu_in1  output  16  second ALU operand (value of rt).
REQ-012 alu_out  input  16  registered ALU result, valid one clock after operands are presented.
REQ-013 done  output  1  one-cycle pulse: writeback completed.
REQ-014 result  output  16  last written-back value.
REQ-015 zf  output  1  zero flag of last writeback (present only with ALU_SEQ_ZF_EN).

Function
REQ-016 Block SHALL contain 8 x 16-bit registers r0..r7, all general purpose and writable.
REQ-017 FSM SHALL have states IDLE, EXEC, WB; ins_ready SHALL equal 1 only in IDLE.
REQ-018 IDLE: on posedge with ins_valid=1, block SHALL latch alu_cnt<=op, alu_in0<=r[rs], alu_in1<=r[rt], capture rd, go to EXEC; with ins_valid=0 remain IDLE, outputs unchanged.
REQ-019 EXEC: next posedge SHALL go to WB unconditionally (ALU samples operands on this edge); alu_cnt/alu_in0/alu_in1 SHALL remain stable through EXEC and WB.
REQ-020 WB: next posedge SHALL write alu_out into r[rd], set result<=alu_out, set done=1, go to IDLE.
REQ-021 done SHALL be high for exactly one cycle (the IDLE cycle following WB) and 0 otherwise.
REQ-022 Latency: instruction accepted at edge N; register write, result and done at edge N+2; next instruction acceptable at edge N+3 (throughput one per 3 cycles).
REQ-023 ins is ignored whenever ins_ready=0; the source SHALL hold ins_valid/ins until accepted.
REQ-024 Operand reads SHALL use register values before the capturing edge (an ld_en write on the same edge is not seen).
REQ-025 ld_en=1 SHALL write ld_data into r[ld_addr] on posedge in any state.
REQ-026 ld_en and WB writing the same register on the same edge: WB value SHALL win; different registers: both writes occur.
REQ-027 rd may equal rs or rt; operands already latched are unaffected by the writeback.
REQ-028 Arithmetic wraps modulo 2^16 (performed by ALU); block SHALL not alter alu_out.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, r0..r7=0, alu_cnt=00, alu_in0=alu_in1=0, result=0, done=0, zf=0.
REQ-030 Reset during EXEC or WB SHALL abort the instruction with no register write and no done pulse.
REQ-031 ins_ready SHALL be 1 while and after reset deasserts (state IDLE).

Configuration
REQ-032 Macro ALU_SEQ_ZF_EN defined: zf port exists; at WB edge zf<=(alu_out==16'h0000), holds otherwise.
REQ-033 Macro undefined: zf port and its register SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, ld r1=0x0005, r2=0x0003; ins op=00 rd=3 rs=1 rt=2 -> alu_in0=0x0005, alu_in1=0x0003 at N+1, r3=0x0008, result=0x0008, done pulse at N+2.
REQ-035 r1=0x0003, r2=0x0005, op=01 rd=4 -> r4=0xFFFE (wrap); with ALU_SEQ_ZF_EN, op=01 rs=rt=1 -> result=0x0000, zf=1.
REQ-036 Hold ins_valid=1 continuously with 3 instructions -> ins_ready low in EXEC/WB, one accept per 3 cycles, 3 done pulses, no instruction lost or duplicated.
REQ-037 ld_en to r3=0x1234 on same edge as WB to r3 (result 0x00FF) -> r3=0x00FF; ld_en to r5 same edge -> r5 also written.
REQ-038 Assert rst=0 mid-EXEC -> all outputs 0 immediately, no done pulse, rd register stays 0; next instruction after release executes normally.
